regfile_param_bypass: RTL and testbench

- Parametrised successor to the 16x32 pipeline register file.
- Configurable word width, register count and read-port count.
- Dedicated PC and link-register update paths, write-to-read bypass, and a per-register pending-write scoreboard that raises read hazards for the decode stage.
- Sits between the ID stage (reads, issue) and the WB/IF stages (writeback, PC update).

---
 rtl/regfile_param_bypass.sv | 60 ++++++
 tb/tb_regfile_param_bypass.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param_bypass.sv
// regfile_param_bypass: parametrised register file with PC/LR update paths, write-to-read bypass
// and a pending-write scoreboard that flags read hazards to decode.
module regfile_param_bypass #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int AW = 4,
    parameter int NRD = 3,
    parameter int PC_IDX = NREGS - 1,
    parameter int LR_IDX = NREGS - 2,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic               clock,
    input  logic               R,
    input  logic               Ld,
    input  logic [AW-1:0]      RW,
    input  logic [WIDTH-1:0]   PW,
    input  logic               PCE,
    input  logic [WIDTH-1:0]   PCin,
    input  logic               BL,
    input  logic [WIDTH-1:0]   PC_4_in,
    input  logic [NRD*AW-1:0]  RA,
    output logic [NRD*WIDTH-1:0] RD,
    output logic [WIDTH-1:0]   PCout,
    input  logic               iss_en,
    input  logic [AW-1:0]      iss_addr,
    output logic [NREGS-1:0]   busy,
    output logic [NRD-1:0]     hazard
);
    if (AW != $clog2(NREGS)) begin : g_bad_aw
        $error("regfile_param_bypass: AW must equal clog2(NREGS)");
    end
    if (PC_IDX == LR_IDX) begin : g_bad_idx
        $error("regfile_param_bypass: PC_IDX and LR_IDX must differ");
    end
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] nxt [NREGS];
    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] busy_nxt;
    genvar i, k;
    // nxt[i] is the value reg i holds after the coming edge; reads and state both use it
    for (i = 0; i < NREGS; i++) begin : g_reg
        localparam bit IS_PC = (i == PC_IDX);
        localparam bit IS_LR = (i == LR_IDX);
        logic gen_wr;
        assign gen_wr = Ld && RW == AW'(i);
        assign clr[i] = (IS_LR && BL) || (IS_PC && PCE) || gen_wr;
        assign nxt[i] = (IS_LR && BL) ? PC_4_in : (IS_PC && PCE) ? PCin : gen_wr ? PW : regs[i];
        assign busy_nxt[i] = (iss_en && iss_addr == AW'(i)) || (busy[i] && !clr[i]);
    end
    always_ff @(posedge clock) begin
        for (int j = 0; j < NREGS; j++)
            regs[j] <= R ? ((j == PC_IDX) ? PC_RESET : '0) : nxt[j];
        busy <= R ? '0 : busy_nxt;
    end
    for (k = 0; k < NRD; k++) begin : g_rd
        assign RD[k*WIDTH +: WIDTH] = nxt[RA[k*AW +: AW]];
        assign hazard[k] = busy[RA[k*AW +: AW]] && !clr[RA[k*AW +: AW]];
    end
    assign PCout = regs[PC_IDX];
endmodule

// File: tb/tb_regfile_param_bypass.sv
// tb_regfile_param_bypass: directed tests on a default 32x16x3 instance and a 16x8x2 instance.
module tb_regfile_param_bypass;
    logic clock = 0;
    always #5 clock = ~clock;
    int n_cmp = 0, n_bad = 0;

    logic R, Ld, PCE, BL, iss_en;
    logic [3:0] RW, iss_addr;
    logic [31:0] PW, PCin, PC_4_in, PCout;
    logic [11:0] RA;
    logic [95:0] RD;
    logic [15:0] busy;
    logic [2:0] hazard;

    logic R_b, Ld_b, PCE_b, BL_b, iss_en_b;
    logic [2:0] RW_b, iss_addr_b;
    logic [15:0] PW_b, PCin_b, PC_4_in_b, PCout_b;
    logic [5:0] RA_b;
    logic [31:0] RD_b;
    logic [7:0] busy_b;
    logic [1:0] hazard_b;

    regfile_param_bypass dut (
        .clock(clock), .R(R), .Ld(Ld), .RW(RW), .PW(PW), .PCE(PCE), .PCin(PCin),
        .BL(BL), .PC_4_in(PC_4_in), .RA(RA), .RD(RD), .PCout(PCout),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy), .hazard(hazard)
    );

    regfile_param_bypass #(.WIDTH(16), .NREGS(8), .AW(3), .NRD(2), .PC_RESET(16'h0040)) dut_b (
        .clock(clock), .R(R_b), .Ld(Ld_b), .RW(RW_b), .PW(PW_b), .PCE(PCE_b), .PCin(PCin_b),
        .BL(BL_b), .PC_4_in(PC_4_in_b), .RA(RA_b), .RD(RD_b), .PCout(PCout_b),
        .iss_en(iss_en_b), .iss_addr(iss_addr_b), .busy(busy_b), .hazard(hazard_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        R = 1; PCE = 1; PCin = 32'h100; Ld = 1; RW = 3; PW = 32'hAA; iss_en = 1; iss_addr = 2;
        tick();
        R = 0; PCE = 0; Ld = 0; iss_en = 0; RA = {4'd15, 4'd2, 4'd3};
        #1;
        n_cmp++; if (PCout !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", PCout, 32'h0); end
        n_cmp++; if (RD[31:0] !== 32'h0) begin n_bad++; $display("FAIL reset_reg3: got %h want %h", RD[31:0], 32'h0); end
        n_cmp++; if (busy !== 16'h0) begin n_bad++; $display("FAIL reset_busy: got %h want %h", busy, 16'h0); end
    endtask

    task automatic test_write_read();
        logic [31:0] exp;
        int a;
        for (int i = 0; i < 14; i++) begin
            Ld = 1; RW = 4'(i); PW = 32'h11111111 * 32'(i);
            tick();
        end
        Ld = 0;
        for (int j = 0; j < 14; j++) begin
            RA = {4'((j + 2) % 14), 4'((j + 1) % 14), 4'(j)};
            #1;
            for (int k = 0; k < 3; k++) begin
                a = (j + k) % 14;
                exp = 32'h11111111 * 32'(a);
                n_cmp++;
                if (RD[k*32 +: 32] !== exp) begin
                    n_bad++; $display("FAIL read_sweep port%0d addr%0d: got %h want %h", k, a, RD[k*32 +: 32], exp);
                end
            end
            RA = {4'(j), 4'(j), 4'(j)};
            #1;
            exp = 32'h11111111 * 32'(j);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (RD[k*32 +: 32] !== exp) begin
                    n_bad++; $display("FAIL read_same port%0d addr%0d: got %h want %h", k, j, RD[k*32 +: 32], exp);
                end
            end
        end
    endtask

    task automatic test_bypass();
        Ld = 1; RW = 5; PW = 32'hDEADBEEF; RA = {4'd15, 4'd6, 4'd5};
        #1;
        n_cmp++; if (RD[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_same_cycle: got %h want %h", RD[31:0], 32'hDEADBEEF); end
        n_cmp++; if (RD[63:32] !== 32'h66666666) begin n_bad++; $display("FAIL bypass_other_port: got %h want %h", RD[63:32], 32'h66666666); end
        tick();
        Ld = 0;
        #1;
        n_cmp++; if (RD[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_stored: got %h want %h", RD[31:0], 32'hDEADBEEF); end
    endtask

    task automatic test_priority();
        BL = 1; PC_4_in = 32'h204; Ld = 1; RW = 14; PW = 32'h55; PCE = 1; PCin = 32'h300;
        RA = {4'd5, 4'd15, 4'd14};
        #1;
        n_cmp++; if (RD[31:0] !== 32'h204) begin n_bad++; $display("FAIL prio_lr_bypass: got %h want %h", RD[31:0], 32'h204); end
        n_cmp++; if (RD[63:32] !== 32'h300) begin n_bad++; $display("FAIL prio_pc_bypass: got %h want %h", RD[63:32], 32'h300); end
        tick();
        BL = 0; Ld = 0; PCE = 0;
        #1;
        n_cmp++; if (RD[31:0] !== 32'h204) begin n_bad++; $display("FAIL prio_lr_stored: got %h want %h", RD[31:0], 32'h204); end
        n_cmp++; if (PCout !== 32'h300) begin n_bad++; $display("FAIL prio_pcout: got %h want %h", PCout, 32'h300); end
        Ld = 1; RW = 15; PW = 32'h400;
        tick();
        Ld = 0;
        n_cmp++; if (PCout !== 32'h400) begin n_bad++; $display("FAIL prio_ld_pc: got %h want %h", PCout, 32'h400); end
        Ld = 1; RW = 15; PW = 32'h999; PCE = 1; PCin = 32'h500;
        tick();
        Ld = 0; PCE = 0;
        n_cmp++; if (PCout !== 32'h500) begin n_bad++; $display("FAIL prio_pce_wins: got %h want %h", PCout, 32'h500); end
    endtask

    task automatic test_scoreboard();
        iss_en = 1; iss_addr = 7; RA = {4'd15, 4'd8, 4'd7};
        #1;
        n_cmp++; if (hazard !== 3'b000) begin n_bad++; $display("FAIL sb_issue_no_hazard: got %b want %b", hazard, 3'b000); end
        tick();
        iss_en = 0;
        n_cmp++; if (busy !== 16'h0080) begin n_bad++; $display("FAIL sb_busy_set: got %h want %h", busy, 16'h0080); end
        n_cmp++; if (hazard !== 3'b001) begin n_bad++; $display("FAIL sb_hazard: got %b want %b", hazard, 3'b001); end
        Ld = 1; RW = 7; PW = 32'h77;
        #1;
        n_cmp++; if (hazard !== 3'b000) begin n_bad++; $display("FAIL sb_hazard_bypassed: got %b want %b", hazard, 3'b000); end
        n_cmp++; if (RD[31:0] !== 32'h77) begin n_bad++; $display("FAIL sb_rd_bypassed: got %h want %h", RD[31:0], 32'h77); end
        tick();
        Ld = 0;
        n_cmp++; if (busy !== 16'h0000) begin n_bad++; $display("FAIL sb_busy_clear: got %h want %h", busy, 16'h0000); end
        iss_en = 1; iss_addr = 7; Ld = 1; RW = 7; PW = 32'h78;
        tick();
        iss_en = 0; Ld = 0;
        n_cmp++; if (busy !== 16'h0080) begin n_bad++; $display("FAIL sb_set_wins: got %h want %h", busy, 16'h0080); end
        Ld = 1; RW = 8; PW = 32'h1;
        #1;
        n_cmp++; if (hazard !== 3'b001) begin n_bad++; $display("FAIL sb_other_write: got %b want %b", hazard, 3'b001); end
        tick();
        Ld = 0;
        n_cmp++; if (busy !== 16'h0080) begin n_bad++; $display("FAIL sb_other_keep: got %h want %h", busy, 16'h0080); end
        iss_en = 1; iss_addr = 15;
        tick();
        iss_en = 0;
        n_cmp++; if (busy !== 16'h8080) begin n_bad++; $display("FAIL sb_pc_busy: got %h want %h", busy, 16'h8080); end
        n_cmp++; if (hazard !== 3'b101) begin n_bad++; $display("FAIL sb_pc_hazard: got %b want %b", hazard, 3'b101); end
        PCE = 1; PCin = 32'h600;
        #1;
        n_cmp++; if (hazard !== 3'b001) begin n_bad++; $display("FAIL sb_pc_bypassed: got %b want %b", hazard, 3'b001); end
        tick();
        PCE = 0;
        n_cmp++; if (busy !== 16'h0080) begin n_bad++; $display("FAIL sb_pc_clear: got %h want %h", busy, 16'h0080); end
        n_cmp++; if (PCout !== 32'h600) begin n_bad++; $display("FAIL sb_pcout: got %h want %h", PCout, 32'h600); end
        iss_en = 1; iss_addr = 14;
        tick();
        iss_en = 0; BL = 1; PC_4_in = 32'h608;
        tick();
        BL = 0;
        n_cmp++; if (busy !== 16'h0080) begin n_bad++; $display("FAIL sb_lr_clear: got %h want %h", busy, 16'h0080); end
    endtask

    task automatic test_param();
        R_b = 1; Ld_b = 1; RW_b = 2; PW_b = 16'h2222; PCE_b = 1; PCin_b = 16'h0100; iss_en_b = 1; iss_addr_b = 4;
        tick();
        R_b = 0; Ld_b = 0; PCE_b = 0; iss_en_b = 0; RA_b = {3'd6, 3'd7};
        #1;
        n_cmp++; if (PCout_b !== 16'h0040) begin n_bad++; $display("FAIL p_reset_pc: got %h want %h", PCout_b, 16'h0040); end
        n_cmp++; if (RD_b[15:0] !== 16'h0040) begin n_bad++; $display("FAIL p_reset_rd_pc: got %h want %h", RD_b[15:0], 16'h0040); end
        n_cmp++; if (RD_b[31:16] !== 16'h0) begin n_bad++; $display("FAIL p_reset_lr: got %h want %h", RD_b[31:16], 16'h0); end
        n_cmp++; if (busy_b !== 8'h00) begin n_bad++; $display("FAIL p_reset_busy: got %h want %h", busy_b, 8'h00); end
        Ld_b = 1; RW_b = 5; PW_b = 16'hBEEF; RA_b = {3'd6, 3'd5};
        #1;
        n_cmp++; if (RD_b[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL p_bypass: got %h want %h", RD_b[15:0], 16'hBEEF); end
        tick();
        Ld_b = 0;
        n_cmp++; if (RD_b[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL p_stored: got %h want %h", RD_b[15:0], 16'hBEEF); end
        BL_b = 1; PC_4_in_b = 16'h1234; Ld_b = 1; RW_b = 6; PW_b = 16'h5555;
        #1;
        n_cmp++; if (RD_b[31:16] !== 16'h1234) begin n_bad++; $display("FAIL p_lr_bypass: got %h want %h", RD_b[31:16], 16'h1234); end
        tick();
        BL_b = 0; Ld_b = 0;
        n_cmp++; if (RD_b[31:16] !== 16'h1234) begin n_bad++; $display("FAIL p_lr_stored: got %h want %h", RD_b[31:16], 16'h1234); end
        iss_en_b = 1; iss_addr_b = 3; RA_b = {3'd6, 3'd3};
        tick();
        iss_en_b = 0;
        n_cmp++; if (busy_b !== 8'h08) begin n_bad++; $display("FAIL p_busy_set: got %h want %h", busy_b, 8'h08); end
        n_cmp++; if (hazard_b !== 2'b01) begin n_bad++; $display("FAIL p_hazard: got %b want %b", hazard_b, 2'b01); end
        Ld_b = 1; RW_b = 3; PW_b = 16'h3333;
        #1;
        n_cmp++; if (hazard_b !== 2'b00) begin n_bad++; $display("FAIL p_hazard_bypassed: got %b want %b", hazard_b, 2'b00); end
        n_cmp++; if (RD_b[15:0] !== 16'h3333) begin n_bad++; $display("FAIL p_rd_bypassed: got %h want %h", RD_b[15:0], 16'h3333); end
        tick();
        Ld_b = 0;
        n_cmp++; if (busy_b !== 8'h00) begin n_bad++; $display("FAIL p_busy_clear: got %h want %h", busy_b, 8'h00); end
        iss_en_b = 1; iss_addr_b = 3; Ld_b = 1; RW_b = 3; PW_b = 16'h3434;
        tick();
        iss_en_b = 0; Ld_b = 0;
        n_cmp++; if (busy_b !== 8'h08) begin n_bad++; $display("FAIL p_set_wins: got %h want %h", busy_b, 8'h08); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        R = 0; Ld = 0; RW = 0; PW = 0; PCE = 0; PCin = 0; BL = 0; PC_4_in = 0; RA = 0; iss_en = 0; iss_addr = 0;
        R_b = 0; Ld_b = 0; RW_b = 0; PW_b = 0; PCE_b = 0; PCin_b = 0; BL_b = 0; PC_4_in_b = 0; RA_b = 0;
        iss_en_b = 0; iss_addr_b = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_priority();
        test_scoreboard();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
